moldudp64_framer: RTL and testbench
===================================

MOLDUDP64_FRAMER -- requirements
Module: moldudp64_framer

Interface
REQ-001 SHALL have parameter MAX_MSG_LEN, default 64, the largest accepted message length in bytes; larger lengths are flagged as errors.
REQ-002 SHALL have parameter HDR_BYTES, default 20, the MoldUDP64 header length (10 session + 8 sequence + 2 count); it is fixed and not overridden.
REQ-003 SHALL have clock  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have reset_n  in  1  synchronous, active-low reset, sampled on clock.
REQ-005 SHALL have in_data  in  8, in_valid  in  1, in_last  in  1: UDP payload byte stream from the IP/UDP filter stage; there is no backpressure.
REQ-006 SHALL have out_data  out  8, out_valid  out  1, out_start  out  1, out_last  out  1: ITCH message body bytes, start/last marking the first and final body byte.
REQ-007 SHALL have out_seq  out  64: sequence number of the message being emitted, stable from out_start through out_last.
REQ-008 SHALL have err_pulse  out  1: one-cycle pulse on any framing error.
REQ-009 SHALL have gap_pulse  out  1 and expected_seq  out  64: gap detection outputs (see Configuration).

Function
REQ-010 SHALL register all outputs; out_* appears exactly 1 cycle after the accepted in_data byte; cycles with in_valid=0 produce no output and hold the FSM.
REQ-011 SHALL implement states HDR, LEN_HI, LEN_LO, BODY, DROP; reset state HDR with byte counter 0.
REQ-012 HDR: count bytes 0..19; latch sequence (bytes 10-17, big-endian) and count (bytes 18-19, big-endian); after byte 19 go to LEN_HI if count is nonzero and not 0xFFFF, else DROP.
REQ-013 LEN_HI/LEN_LO: assemble a 16-bit big-endian length; length 0 -> decrement remaining count, increment message seq, return to LEN_HI (or DROP if count exhausted); length > MAX_MSG_LEN -> err_pulse and DROP; otherwise BODY.
REQ-014 BODY: forward each byte; out_start on body byte 0; out_last on byte length-1; then decrement remaining count, increment out_seq, and go to LEN_HI, or to DROP if remaining count is 0.
REQ-015 DROP: discard bytes until in_last, then go to HDR; bytes after the final message in a packet are discarded silently.
REQ-016 in_last while in HDR/LEN_HI/LEN_LO (truncated packet) SHALL pulse err_pulse and go to HDR; an exception is in_last on byte 19 with count 0 or 0xFFFF (heartbeat/end-of-session), which SHALL be legal.
REQ-017 in_last in BODY before byte length-1 SHALL assert out_last on that byte, pulse err_pulse in the same cycle, and go to HDR.
REQ-018 in_last on the final body byte with remaining count still >0 SHALL pulse err_pulse and go to HDR.
REQ-019 Every in_last SHALL force the next state to HDR regardless of current state.

Reset
REQ-020 While reset_n=0 at a clock edge, out_valid, out_start, out_last, err_pulse, gap_pulse SHALL be 0, out_data 0, out_seq 0, expected_seq 0, state HDR, counters 0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet; after release, bytes until the next in_last are treated as a new header (documented; no resync is attempted).

Configuration
REQ-022 Macro MOLD_SEQ_CHECK_EN SHALL compile in gap detection: after the header, if a prior packet was seen and the header seq is not equal to expected_seq, pulse gap_pulse once, 1 cycle after byte 19; expected_seq becomes header seq + count at packet end (heartbeat: header seq).
REQ-023 Without MOLD_SEQ_CHECK_EN, gap_pulse and expected_seq SHALL be tied to 0 and no comparator or 64-bit adder is present.

Structure
REQ-024 A shared package moldudp64_pkg SHALL hold the state enum, HDR_BYTES, the field offsets (SEQ_OFS=10, CNT_OFS=18), and END_OF_SESSION=16'hFFFF.
REQ-025 Header field capture SHALL be a sub-module mold_hdr_capture (byte index in, seq/count out); everything else stays in moldudp64_framer.

Verification
REQ-026 Packet seq=5, count=2, messages len 3 {A1 A2 A3} and len 1 {B1} -> out_data A1,A2,A3,B1; starts on A1,B1; lasts on A3,B1; out_seq 5 then 6; no err.
REQ-027 Heartbeat, 20 bytes with count=0 and in_last on byte 19 -> no out_valid, no err_pulse; with the macro, expected_seq unchanged.
REQ-028 Length 0x0100 with MAX_MSG_LEN=64 -> err_pulse once, no output, next packet with valid framing is parsed normally.
REQ-029 in_last on body byte 1 of a 3-byte message -> out_last and err_pulse in the same cycle, FSM returns to HDR.
REQ-030 Macro enabled: packet seq=5 count=2, then packet seq=9 -> gap_pulse once after the second header, expected_seq=7 before that header and 10 after.
REQ-031 Reset_n low during BODY with in_valid gaps -> all outputs 0 next cycle; the packet after the following in_last parses correctly.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// rtl/moldudp64_pkg.sv - shared MoldUDP64 framer constants and FSM state encoding
package moldudp64_pkg;

  localparam int          HDR_BYTES      = 20;
  localparam logic [4:0]  SEQ_OFS        = 5'd10;
  localparam logic [4:0]  CNT_OFS        = 5'd18;
  localparam logic [15:0] END_OF_SESSION = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_BODY,
    ST_DROP
  } state_t;

endpackage

// File: rtl/mold_hdr_capture.sv
// rtl/mold_hdr_capture.sv - latches sequence and message count fields of the MoldUDP64 header
module mold_hdr_capture
  import moldudp64_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        capture,
  input  logic [4:0]  byte_idx,
  input  logic [7:0]  byte_data,
  output logic [63:0] hdr_seq,
  output logic [15:0] hdr_count
);

  logic [15:0] count_q;

  // Shift sequence bytes in big-endian order; count bytes land in fixed halves.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hdr_seq <= '0;
      count_q <= '0;
    end else if (capture) begin
      if (byte_idx >= SEQ_OFS && byte_idx < CNT_OFS) begin
        hdr_seq <= {hdr_seq[55:0], byte_data};
      end
      if (byte_idx == CNT_OFS) begin
        count_q[15:8] <= byte_data;
      end
      if (byte_idx == CNT_OFS + 5'd1) begin
        count_q[7:0] <= byte_data;
      end
    end
  end

  // The framer decides on the count while byte 19 is presented, so bypass the low byte then.
  assign hdr_count = (capture && byte_idx == CNT_OFS + 5'd1) ? {count_q[15:8], byte_data} : count_q;

endmodule

// File: rtl/moldudp64_framer.sv
// rtl/moldudp64_framer.sv - MoldUDP64 payload to ITCH message framer; MOLD_SEQ_CHECK_EN adds gap detection
module moldudp64_framer #(
  parameter int MAX_MSG_LEN = 64,
  parameter int HDR_BYTES   = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_start,
  output logic        out_last,
  output logic [63:0] out_seq,
  output logic        err_pulse,
  output logic        gap_pulse,
  output logic [63:0] expected_seq
);

  import moldudp64_pkg::*;

  localparam logic [4:0]  HDR_LAST = 5'(HDR_BYTES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_MSG_LEN);

  state_t      state, state_d;
  logic [4:0]  hdr_cnt, hdr_cnt_d;
  logic [15:0] rem_cnt, rem_d;
  logic [63:0] msg_seq, msg_seq_d;
  logic [7:0]  len_hi, len_hi_d;
  logic [15:0] msg_len, msg_len_d;
  logic [15:0] body_cnt, body_cnt_d;
  logic [7:0]  out_data_d;
  logic [63:0] out_seq_d;
  logic        out_valid_d, out_start_d, out_last_d, err_d;

  logic        hdr_capture;
  logic [63:0] hdr_seq;
  logic [15:0] hdr_count;
  logic        no_msgs;
  logic [15:0] rem_m1;
  logic [15:0] len_now;
  logic        body_last;

  assign hdr_capture = in_valid && (state == ST_HDR);

  mold_hdr_capture u_hdr_capture (
    .clock     (clock),
    .reset_n   (reset_n),
    .capture   (hdr_capture),
    .byte_idx  (hdr_cnt),
    .byte_data (in_data),
    .hdr_seq   (hdr_seq),
    .hdr_count (hdr_count)
  );

  // Heartbeat (count 0) and end-of-session (0xFFFF) carry no messages.
  assign no_msgs   = (hdr_count == 16'd0) || (hdr_count == END_OF_SESSION);
  assign rem_m1    = rem_cnt - 16'd1;
  assign len_now   = {len_hi, in_data};
  assign body_last = (body_cnt == msg_len - 16'd1);

  // State and output registers; everything is reloaded from the next-state logic.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_HDR;
      hdr_cnt   <= '0;
      rem_cnt   <= '0;
      msg_seq   <= '0;
      len_hi    <= '0;
      msg_len   <= '0;
      body_cnt  <= '0;
      out_data  <= '0;
      out_seq   <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_d;
      hdr_cnt   <= hdr_cnt_d;
      rem_cnt   <= rem_d;
      msg_seq   <= msg_seq_d;
      len_hi    <= len_hi_d;
      msg_len   <= msg_len_d;
      body_cnt  <= body_cnt_d;
      out_data  <= out_data_d;
      out_seq   <= out_seq_d;
      out_valid <= out_valid_d;
      out_start <= out_start_d;
      out_last  <= out_last_d;
      err_pulse <= err_d;
    end
  end

  // Next-state and output decode; idle cycles hold every counter and emit nothing.
  always_comb begin
    state_d     = state;
    hdr_cnt_d   = hdr_cnt;
    rem_d       = rem_cnt;
    msg_seq_d   = msg_seq;
    len_hi_d    = len_hi;
    msg_len_d   = msg_len;
    body_cnt_d  = body_cnt;
    out_data_d  = out_data;
    out_seq_d   = out_seq;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_last_d  = 1'b0;
    err_d       = 1'b0;
    if (in_valid) begin
      unique case (state)
        ST_HDR: begin
          if (hdr_cnt == HDR_LAST) begin
            hdr_cnt_d = '0;
            if (in_last) begin
              // Ending on the last header byte is only legal for message-less packets.
              state_d = ST_HDR;
              err_d   = !no_msgs;
            end else if (no_msgs) begin
              state_d = ST_DROP;
            end else begin
              state_d   = ST_LEN_HI;
              rem_d     = hdr_count;
              msg_seq_d = hdr_seq;
            end
          end else if (in_last) begin
            hdr_cnt_d = '0;
            err_d     = 1'b1;
          end else begin
            hdr_cnt_d = hdr_cnt + 5'd1;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = in_data;
          if (in_last) begin
            state_d = ST_HDR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (in_last) begin
            state_d = ST_HDR;
            err_d   = 1'b1;
          end else if (len_now == 16'd0) begin
            rem_d     = rem_m1;
            msg_seq_d = msg_seq + 64'd1;
            state_d   = (rem_m1 == 16'd0) ? ST_DROP : ST_LEN_HI;
          end else if (len_now > MAX_LEN) begin
            state_d = ST_DROP;
            err_d   = 1'b1;
          end else begin
            msg_len_d  = len_now;
            body_cnt_d = '0;
            state_d    = ST_BODY;
          end
        end
        ST_BODY: begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_seq_d   = msg_seq;
          out_start_d = (body_cnt == 16'd0);
          out_last_d  = body_last || in_last;
          if (in_last) begin
            // A packet may only end on the final byte of its final message.
            state_d = ST_HDR;
            err_d   = !body_last || (rem_m1 != 16'd0);
          end else if (body_last) begin
            rem_d     = rem_m1;
            msg_seq_d = msg_seq + 64'd1;
            state_d   = (rem_m1 == 16'd0) ? ST_DROP : ST_LEN_HI;
          end else begin
            body_cnt_d = body_cnt + 16'd1;
          end
        end
        ST_DROP: begin
          if (in_last) begin
            state_d = ST_HDR;
          end
        end
        default: begin
          state_d   = ST_HDR;
          hdr_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef MOLD_SEQ_CHECK_EN
  logic        hdr_end, pkt_end;
  logic        seen_q, hdr_done_q, gap_q;
  logic [63:0] exp_q, pend_q, pend_now;

  assign hdr_end  = in_valid && (state == ST_HDR) && (hdr_cnt == HDR_LAST);
  assign pkt_end  = in_valid && in_last;
  assign pend_now = hdr_seq + (no_msgs ? 64'd0 : {48'd0, hdr_count});

  // Compare each completed header against the prediction; commit the new prediction at packet end.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seen_q     <= 1'b0;
      hdr_done_q <= 1'b0;
      gap_q      <= 1'b0;
      exp_q      <= '0;
      pend_q     <= '0;
    end else begin
      gap_q <= hdr_end && seen_q && (hdr_seq != exp_q);
      if (hdr_end) begin
        pend_q <= pend_now;
      end
      if (pkt_end && (hdr_end || hdr_done_q)) begin
        exp_q  <= hdr_end ? pend_now : pend_q;
        seen_q <= 1'b1;
      end
      if (pkt_end) begin
        hdr_done_q <= 1'b0;
      end else if (hdr_end) begin
        hdr_done_q <= 1'b1;
      end
    end
  end

  assign gap_pulse    = gap_q;
  assign expected_seq = exp_q;
`else
  assign gap_pulse    = 1'b0;
  assign expected_seq = '0;
`endif

endmodule

// File: tb/tb_moldudp64_framer.sv
// tb/tb_moldudp64_framer.sv - self-checking bench for moldudp64_framer
module tb_moldudp64_framer;

  localparam int MAX = 64;
  localparam int HDR = 20;
`ifdef MOLD_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_start;
  logic        out_last;
  logic [63:0] out_seq;
  logic        err_pulse;
  logic        gap_pulse;
  logic [63:0] expected_seq;

  moldudp64_framer #(.MAX_MSG_LEN(64), .HDR_BYTES(20)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_start    (out_start),
    .out_last     (out_last),
    .out_seq      (out_seq),
    .err_pulse    (err_pulse),
    .gap_pulse    (gap_pulse),
    .expected_seq (expected_seq)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  data;
    logic        start;
    logic        last;
    logic [63:0] seq;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cur;
  logic [7:0]  pkt [0:255];
  int          pn;
  int          ncmp = 0;
  int          nfail = 0;
  int          err_seen = 0;
  int          gap_seen = 0;
  int          m_err, m_gap;
  bit          m_seen = 1'b0;
  logic [63:0] m_exp = '0;

  // Every body beat the DUT emits must be the next one the model predicts.
  always @(negedge clock) begin
    if (out_valid) begin
      ncmp++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL out_beat: got unexpected beat data=%h start=%0d last=%0d seq=%0h, required none", out_data, out_start, out_last, out_seq);
      end else begin
        cur = exp_q.pop_front();
        if ({out_data, out_start, out_last, out_seq} !== cur) begin
          nfail++;
          $display("FAIL out_beat: got data=%h start=%0d last=%0d seq=%0h, required data=%h start=%0d last=%0d seq=%0h",
                   out_data, out_start, out_last, out_seq, cur.data, cur.start, cur.last, cur.seq);
        end
      end
    end
    if (err_pulse) err_seen++;
    if (gap_pulse) gap_seen++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    ncmp++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic put(input logic [7:0] b);
    pkt[pn] = b;
    pn++;
  endtask

  task automatic hdr(input logic [63:0] seq, input logic [15:0] cnt);
    pn = 0;
    for (int i = 0; i < 10; i++) put(8'h40 + 8'(i));
    for (int i = 7; i >= 0; i--) put(seq[i*8 +: 8]);
    put(cnt[15:8]);
    put(cnt[7:0]);
  endtask

  task automatic msg(input int len, input logic [7:0] base);
    put(8'(len >> 8));
    put(8'(len));
    for (int i = 0; i < len; i++) put(base + 8'(i));
  endtask

  task automatic push_ev(input logic [7:0] d, input logic s, input logic l, input logic [63:0] q);
    ev_t e;
    e.data = d; e.start = s; e.last = l; e.seq = q;
    exp_q.push_back(e);
  endtask

  // Packet-level reading of the MoldUDP64 rules: what beats, errors and gaps a whole packet yields.
  task automatic model_pkt(input int n);
    logic [63:0] seq;
    logic [15:0] cnt, len;
    int pos, rem, emit;
    bit done;
    m_err = 0;
    m_gap = 0;
    if (n < HDR) begin
      m_err = 1;
      return;
    end
    seq = '0;
    for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt[i]};
    cnt = {pkt[18], pkt[19]};
    if (SEQ_EN) begin
      if (m_seen && seq != m_exp) m_gap = 1;
      m_exp  = seq + ((cnt == 16'd0 || cnt == 16'hFFFF) ? 64'd0 : 64'(cnt));
      m_seen = 1'b1;
    end
    if (cnt == 16'd0 || cnt == 16'hFFFF) return;
    if (n == HDR) begin
      m_err = 1;
      return;
    end
    pos = HDR;
    rem = int'(cnt);
    done = 1'b0;
    while (!done) begin
      if (pos + 1 >= n - 1) begin
        m_err = 1;
        done = 1'b1;
      end else begin
        len = {pkt[pos], pkt[pos+1]};
        pos += 2;
        if (len == 16'd0) begin
          rem--;
          seq++;
          if (rem == 0) done = 1'b1;
        end else if (int'(len) > MAX) begin
          m_err = 1;
          done = 1'b1;
        end else begin
          emit = (int'(len) < n - pos) ? int'(len) : n - pos;
          for (int k = 0; k < emit; k++) push_ev(pkt[pos+k], k == 0, k == emit - 1, seq);
          if (emit < int'(len)) begin
            m_err = 1;
            done = 1'b1;
          end else if (pos + int'(len) == n) begin
            if (rem > 1) m_err = 1;
            done = 1'b1;
          end else begin
            rem--;
            seq++;
            pos += int'(len);
            if (rem == 0) done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    @(negedge clock);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_and_check(input int n, input bit gaps);
    err_seen = 0;
    gap_seen = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(pkt[i], i == n - 1);
      if (gaps && (i % 3 == 1)) idle(1);
    end
    idle(3);
    check("err_count", 64'(err_seen), 64'(m_err));
    check("gap_count", 64'(gap_seen), 64'(m_gap));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("expected_seq", expected_seq, m_exp);
  endtask

  task automatic run_pkt(input bit gaps);
    model_pkt(pn);
    send_and_check(pn, gaps);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_flags", {56'd0, out_valid, out_start, out_last, err_pulse, gap_pulse, 3'd0}, 64'd0);
    check("reset_data", {56'd0, out_data}, 64'd0);
    check("reset_out_seq", out_seq, 64'd0);
    check("reset_expected_seq", expected_seq, 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Two messages: seq 5 {A1 A2 A3}, seq 6 {B1}.
    hdr(64'd5, 16'd2);
    msg(3, 8'hA1);
    msg(1, 8'hB1);
    model_pkt(pn);
    check("model_beats", 64'(exp_q.size()), 64'd4);
    check("model_data", {32'd0, exp_q[0].data, exp_q[1].data, exp_q[2].data, exp_q[3].data}, 64'hA1A2A3B1);
    check("model_starts", {60'd0, exp_q[0].start, exp_q[1].start, exp_q[2].start, exp_q[3].start}, 64'b1001);
    check("model_lasts", {60'd0, exp_q[0].last, exp_q[1].last, exp_q[2].last, exp_q[3].last}, 64'b0011);
    check("model_seq_first", exp_q[0].seq, 64'd5);
    check("model_seq_last", exp_q[3].seq, 64'd6);
    check("model_err", 64'(m_err), 64'd0);
    send_and_check(pn, 1'b0);
    check("exp_seq_before_gap", expected_seq, SEQ_EN ? 64'd7 : 64'd0);

    // Sequence jump to 9 flags a gap when checking is compiled in.
    hdr(64'd9, 16'd1);
    msg(2, 8'hD1);
    model_pkt(pn);
    check("model_gap", 64'(m_gap), 64'(SEQ_EN));
    send_and_check(pn, 1'b1);
    check("exp_seq_after_gap", expected_seq, SEQ_EN ? 64'd10 : 64'd0);

    // Heartbeat and end-of-session, both ending on header byte 19.
    hdr(64'd10, 16'd0);
    run_pkt(1'b0);
    hdr(64'd10, 16'hFFFF);
    run_pkt(1'b1);

    // Oversized length 0x0100.
    hdr(64'd10, 16'd1);
    put(8'h01); put(8'h00); put(8'h55); put(8'h56); put(8'h57);
    model_pkt(pn);
    check("model_len_err", 64'(m_err), 64'd1);
    check("model_len_beats", 64'(exp_q.size()), 64'd0);
    send_and_check(pn, 1'b0);

    // Zero-length message, maximum-length message, one-byte message, trailing bytes dropped.
    hdr(64'd11, 16'd3);
    msg(0, 8'h00);
    msg(64, 8'h00);
    msg(1, 8'hEE);
    put(8'h77); put(8'h78);
    run_pkt(1'b1);

    // Length one beyond the maximum.
    hdr(64'd14, 16'd1);
    msg(0, 8'h00);
    pn -= 1;
    pkt[pn] = 8'd65; pn++;
    put(8'h01); put(8'h02); put(8'h03);
    run_pkt(1'b0);

    // Packet ends on body byte 1 of a 3-byte message.
    hdr(64'd15, 16'd1);
    put(8'h00); put(8'h03); put(8'hC1); put(8'hC2);
    model_pkt(pn);
    check("model_trunc_beats", 64'(exp_q.size()), 64'd2);
    check("model_trunc_last", {63'd0, exp_q[1].last}, 64'd1);
    check("model_trunc_err", 64'(m_err), 64'd1);
    send_and_check(pn, 1'b1);

    // Packet ends on a message's final byte while one more message is still owed.
    hdr(64'd16, 16'd2);
    msg(1, 8'hF0);
    run_pkt(1'b0);

    // Truncated header.
    hdr(64'd18, 16'd1);
    pn = 10;
    run_pkt(1'b0);

    // Reset in the middle of a body with idle gaps.
    hdr(64'h20, 16'd1);
    msg(4, 8'hC1);
    push_ev(8'hC1, 1'b1, 1'b0, 64'h20);
    push_ev(8'hC2, 1'b0, 1'b0, 64'h20);
    for (int i = 0; i < 24; i++) begin
      send_byte(pkt[i], 1'b0);
      if (i % 3 == 1) idle(1);
    end
    idle(2);
    check("pre_reset_beats", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    in_last  = 1'b0;
    @(negedge clock);
    check("midreset_flags", {56'd0, out_valid, out_start, out_last, err_pulse, gap_pulse, 3'd0}, 64'd0);
    check("midreset_data", {56'd0, out_data}, 64'd0);
    check("midreset_out_seq", out_seq, 64'd0);
    check("midreset_expected_seq", expected_seq, 64'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    m_seen   = 1'b0;
    m_exp    = '0;
    idle(1);
    pn = 0;
    put(8'hC4);
    run_pkt(1'b0);
    hdr(64'h30, 16'd1);
    msg(2, 8'hE1);
    run_pkt(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
